// File: rtl/pipeline_mem.sv
// pipeline_mem: MEM stage of the pipelined CPU. Holds the data RAM and the
// memory-mapped peripherals (timer, LEDs, seven-segment, switches, systick).
//
// Ports:
//   clk           single clock, rising-edge state updates
//   reset         asynchronous active-high reset (peripheral registers only)
//   MEM_ALUOut    byte address from EX/MEM; bits [1:0] are ignored
//   MEM_dataB     store data, already forwarded
//   MEM_MemRead   load strobe, read result is combinational
//   MEM_MemWrite  store strobe, written on the next rising edge
//   switch        board switches, read at 0x40000010
//   MEM_ReadData  load result, zero whenever MEM_MemRead is low
//   led           LED register (0x4000000C)
//   digi          seven-segment register (0x40000014)
//   IRQ           timer interrupt request, TCON[1] & TCON[2]
module pipeline_mem #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_dataB,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [7:0]  switch,
  output logic [31:0] MEM_ReadData,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        IRQ
);

  localparam int DATA_W = 32;
  localparam int AW     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

  logic [DATA_W-1:0] ram [RAM_WORDS];

  logic [DATA_W-1:0] th;
  logic [DATA_W-1:0] tl;
  logic [2:0]        tcon;
  logic [DATA_W-1:0] systick;

  logic [31:0]       word_addr;
  logic              ram_hit;
  logic [AW-1:0]     ram_idx;
  logic [DATA_W-1:0] rdata;
  logic              unused_addr_bits;

  // Word addressing: the byte offset within a word never affects decode.
  assign word_addr        = {MEM_ALUOut[31:2], 2'b00};
  assign unused_addr_bits = ^MEM_ALUOut[1:0];
  assign ram_hit          = ({2'b00, MEM_ALUOut[31:2]} < 32'(RAM_WORDS));
  assign ram_idx          = MEM_ALUOut[AW+1:2];

  // RAM: no reset, written one edge after the store strobe.
  always_ff @(posedge clk) begin
    if (MEM_MemWrite && ram_hit) begin
      ram[ram_idx] <= MEM_dataB;
    end
  end

  // Peripheral registers. Timer/systick updates come first so that a CPU
  // store in the same cycle overrides them (last non-blocking write wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;

      if (tcon[0]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[1]) begin
            tcon[2] <= 1'b1;
          end
        end else begin
          tl <= tl + 32'd1;
        end
      end

      if (MEM_MemWrite) begin
        case (word_addr)
          ADDR_TH:   th   <= MEM_dataB;
          ADDR_TL:   tl   <= MEM_dataB;
          ADDR_TCON: tcon <= MEM_dataB[2:0];
          ADDR_LED:  led  <= MEM_dataB[7:0];
          ADDR_DIGI: digi <= MEM_dataB[11:0];
          default:   ;
        endcase
      end
    end
  end

  // Combinational read path; peripheral reads are forced to zero while
  // reset is held so nothing (including the switches) leaks through.
  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[ram_idx];
    end else if (!reset) begin
      case (word_addr)
        ADDR_TH:      rdata = th;
        ADDR_TL:      rdata = tl;
        ADDR_TCON:    rdata = {29'd0, tcon};
        ADDR_LED:     rdata = {24'd0, led};
        ADDR_SWITCH:  rdata = {24'd0, switch};
        ADDR_DIGI:    rdata = {20'd0, digi};
        ADDR_SYSTICK: rdata = systick;
        default:      rdata = '0;
      endcase
    end
  end

  assign MEM_ReadData = MEM_MemRead ? rdata : '0;
  assign IRQ          = tcon[1] & tcon[2];

endmodule

// File: doc/pipeline_mem.md
PIPELINE_MEM -- requirements
Module: pipeline_MEM

Interface
REQ-001 Parameter RAM_WORDS, default 256: data RAM depth in 32-bit words, power of two, at most 256.
REQ-002 clk  input  1: single clock; all state updates on rising edge.
REQ-003 reset  input  1: asynchronous, active-high reset.
REQ-004 MEM_ALUOut  input  32: byte address from the EX/MEM register (the EX-stage ALU result).
REQ-005 MEM_dataB  input  32: store data, already forwarded.
REQ-006 MEM_MemRead  input  1: load strobe for the current cycle.
REQ-007 MEM_MemWrite  input  1: store strobe for the current cycle.
REQ-008 switch  input  8: board switches, sampled directly.
REQ-009 MEM_ReadData  output  32: load result, feeds MEM/WB and the EXMEMdata forward path.
REQ-010 led  output  8: LED register.
REQ-011 digi  output  12: seven-segment register.
REQ-012 IRQ  output  1: timer interrupt request to the PC/hazard logic.

Function
REQ-013 Address decode uses word addressing; MEM_ALUOut[1:0] shall be ignored.
REQ-014 RAM window: 0x00000000 to 4*RAM_WORDS-1.
- Load: read is combinational, in the same cycle as MEM_MemRead.
- Store: written at the rising clk edge when MEM_MemWrite=1.
REQ-015 Peripheral map (registers are R/W unless noted):
- 0x40000000 TH (32)
- 0x40000004 TL (32)
- 0x40000008 TCON[2:0]
- 0x4000000C led[7:0]
- 0x40000010 switch (read-only)
- 0x40000014 digi[11:0]
- 0x40000018 systick (read-only)
REQ-016 Unmapped addresses, and addresses beyond the RAM window: reads return 0, writes have no effect.
REQ-017 MEM_ReadData shall be 0 whenever MEM_MemRead=0.
REQ-018 Narrow registers read zero-extended to 32 bits; writes to them take the low bits of MEM_dataB.
REQ-019 TCON bits: [0] = timer enable, [1] = interrupt enable, [2] = interrupt status.
REQ-020 Timer behaviour:
- When TCON[0]=1, TL increments by 1 every cycle.
- When TL=0xFFFFFFFF with TCON[0]=1: the next edge loads TL<=TH, and sets TCON[2]<=1 if TCON[1]=1.
- When TCON[0]=0, TL holds.
REQ-021 IRQ = TCON[1] & TCON[2], combinational from the registers.
REQ-022 systick increments every cycle, wraps 0xFFFFFFFF->0, and ignores writes.
REQ-023 Simultaneous events, CPU store vs timer update:
- A store to TL in the same cycle as an increment or reload wins; TL takes MEM_dataB.
- A store to TCON in the same cycle as a TCON[2] set wins; TCON takes MEM_dataB[2:0].
REQ-024 Interrupt clear: a store to TCON with bit2=0 clears TCON[2]; no other mechanism clears it.
REQ-025 MEM_MemRead and MEM_MemWrite both high: the store is performed, and the read returns the pre-store value.
REQ-026 Load latency is 0 cycles; store latency is 1 edge. No stall or handshake outputs.

Reset
REQ-027 On reset assertion, asynchronously:
- TH, TL, TCON, led, digi and systick go to 0.
- IRQ is therefore 0.
REQ-028 RAM contents are not reset; RAM reads are undefined until written.
REQ-029 Reset asserted mid-count aborts the timer immediately. After deassertion, TL stays 0 until TCON[0] is written to 1.
REQ-030 MEM_ReadData follows REQ-017 during reset; peripheral reads return 0.

Verification
REQ-031 RAM round trip: store 0xDEADBEEF to 0x00000010, then load 0x00000013 -> 0xDEADBEEF.
REQ-032 Out-of-range: store to 0x00000400 (RAM_WORDS=256), then load 0x00000400 -> 0; address 0x00000000 unchanged.
REQ-033 Timer reload and interrupt:
- Setup: TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3'b011.
- Expected: TL=0xFFFFFFFF after 1 edge; after the 2nd edge TL=0xFFFFFFFD and IRQ=1.
- Then store TCON=3'b011 -> IRQ=0 after the edge.
REQ-034 Collision: with TCON[0]=1, store TL=0x00000005 in the same cycle as an increment -> TL=0x00000005, then 0x00000006 next cycle.
REQ-035 Peripherals:
- Store led=0x000000A5 -> led=8'hA5.
- Drive switch=8'h3C and load 0x40000010 -> 0x0000003C.
- Store 0x40000018 -> systick unaffected, keeps incrementing.
REQ-036 Reset mid-count: assert reset with TL=0x00001234 and IRQ=1 -> TL, TCON, led, digi and systick read 0 and IRQ=0 before the next clk edge.
